fpu_mult_seq: RTL and testbench
===============================

Name: fpu_mult_seq

Overview:
Sequential IEEE-754-style floating-point multiplier. It is the responder side of the FPU controller's start_mult/done_mult handshake. The controller pulses start; the block latches both operands, runs a shift-add mantissa multiply, normalizes, handles special values, then pulses done with the result held stable. Single-precision by default, with widths set by parameters.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit implied)
BIAS, 127, exponent bias; must equal 2^(EXP_W-1)-1

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  request; sampled only in IDLE (driven by controller's start_mult)
a  input  1+EXP_W+MAN_W  operand A {sign, exp, frac}; sampled with start
b  input  1+EXP_W+MAN_W  operand B; sampled with start
result  output  1+EXP_W+MAN_W  product; valid from done pulse until next accepted start
done  output  1  one-cycle pulse, result ready (to controller's done_mult)
busy  output  1  high from the edge after acceptance through the edge that raises done

Behaviour:
- Reset (async, any state): state=IDLE; result=0, done=0, busy=0; counter, accumulator and operand registers cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, MULT, NORM.
- IDLE: when start=1 at edge E0, latch a and b. Set the mantissas to {1'b1, frac}, or {1'b0, frac} when exp==0. Clear the accumulator (2*(MAN_W+1) bits), set counter=0, busy=1, enter MULT. done=0 in every state except the cycle after NORM.
- MULT: each edge, if the multiplier LSB=1 add the shifted multiplicand to the accumulator. Shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter.
- After MAN_W+1 MULT edges (E1..E24 by default), go to NORM.
- NORM (one edge, E25 by default): compute the result, register it, set done=1 and busy=0, return to IDLE.
- Latency: done high for the single cycle following edge E(MAN_W+2); 25 cycles by default.
- start while busy: ignored, with no effect on operands or timing.
- start held high in IDLE after done: accepted as a new request on the next edge.
- Sign: sa XOR sb, applied to all outputs except NaN.
- Exponent: e = ea + eb - BIAS, computed signed with EXP_W+2 bits.
- Normalization: if accumulator MSB=1, e += 1 and frac = acc[MSB-1 -: MAN_W]. Otherwise frac = acc[MSB-2 -: MAN_W].
- Rounding: truncation (round toward zero). No sticky bit.
- Priority of special cases, highest first:
  1. Either operand NaN (exp all ones, frac≠0), or Inf×zero: canonical NaN = sign 0, exp all ones, frac MSB 1, rest 0 (0x7FC00000).
  2. Either operand Inf: signed Inf.
  3. Either operand exp==0 (zero or denormal, flushed): signed zero.
  4. e >= 2^EXP_W-1: signed Inf (overflow).
  5. e <= 0: signed zero (underflow flush, no denormal output).
  6. Otherwise: normal packed result.
- Special cases still take the full latency; there is no early done.
- result holds its value in IDLE. It changes only at the NORM edge or on reset.

Test Plan:
- Reset mid-op: start at E0, reset asserted at E10 -> done, busy and result go to 0 asynchronously, state IDLE; a new start then completes normally with 25-cycle latency.
- Basic values:
  - a=0x3FC00000 (1.5), b=0x40000000 (2.0), start 1 cycle -> busy for 25 cycles, done 1 cycle, result=0x40400000 (3.0).
  - a=0xC0000000 (-2), b=0x40400000 (3) -> result=0xC0C00000 (-6); sign and normalize-shift path.
- Specials:
  - a=0x7F800000, b=0x00000000 -> 0x7FC00000.
  - a=0x80000000, b=0x40400000 -> 0x80000000.
  - a=0xFF800000, b=0x40000000 -> 0xFF800000.
  - Each with latency 25.
- Overflow/underflow:
  - 0x7F000000 × 0x7F000000 -> 0x7F800000.
  - 0x00800000 × 0x00800000 -> 0x00000000.
- Handshake: start held high for 30 cycles with operands changing on cycle 5 -> first result uses the cycle-0 operands. A second operation starts the cycle after done, and result stays stable between done and the next NORM.

Source files
------------

// File: rtl/fpu_mult_seq_if.sv
// Start/done handshake bundle between the FPU controller (master) and the
// sequential multiplier (slave).
interface fpu_mult_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         done;
    logic         busy;

    modport master (
        output start, a, b,
        input  result, done, busy
    );

    modport slave (
        input  start, a, b,
        output result, done, busy
    );
endinterface

// File: rtl/fpu_mult_seq.sv
// Sequential floating-point multiplier: shift-add mantissa product over
// MAN_W+1 cycles, then one normalize/special-case cycle, truncating rounding.
module fpu_mult_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic          clock,
    input  logic          reset,
    fpu_mult_seq_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int M     = MAN_W + 1;
    localparam int ACC_W = 2 * M;
    localparam int CNT_W = $clog2(M + 1);
    localparam int EW    = EXP_W + 2;

    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(M - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] E_BIAS   = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO   = '0;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MULT, NORM} state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, a_next;
    logic [W-1:0]       b_reg, b_next;
    logic [ACC_W-1:0]   mcand_reg, mcand_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [M-1:0]       mplier_reg, mplier_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [W-1:0]       result_reg, result_next;
    logic               done_reg, done_next;
    logic               busy_reg, busy_next;

    // Operand field decode from the latched operands
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_r;

    assign ea     = a_reg[W-2 -: EXP_W];
    assign eb     = b_reg[W-2 -: EXP_W];
    assign fa     = a_reg[MAN_W-1:0];
    assign fb     = b_reg[MAN_W-1:0];
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign sign_r = a_reg[W-1] ^ b_reg[W-1];

    logic signed [EW-1:0] e_sum, e_norm;
    logic [MAN_W-1:0]     frac_norm;
    logic [W-1:0]         norm_result;

    always_comb begin
        e_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - E_BIAS;
        // Product of two [1,2) mantissas lies in [1,4): top bit set means one extra binade
        if (acc_reg[ACC_W-1]) begin
            e_norm    = e_sum + EW'(1);
            frac_norm = acc_reg[ACC_W-2 -: MAN_W];
        end else begin
            e_norm    = e_sum;
            frac_norm = acc_reg[ACC_W-3 -: MAN_W];
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            norm_result = QNAN;
        else if (a_inf || b_inf)
            norm_result = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
        else if (a_zero || b_zero)
            norm_result = {sign_r, {(W-1){1'b0}}};
        else if (e_norm >= E_MAX)
            norm_result = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
        else if (e_norm <= E_ZERO)
            norm_result = {sign_r, {(W-1){1'b0}}};
        else
            norm_result = {sign_r, e_norm[EXP_W-1:0], frac_norm};
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        mcand_next  = mcand_reg;
        acc_next    = acc_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        busy_next   = busy_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    a_next      = bus.a;
                    b_next      = bus.b;
                    // Hidden bit is 1 only for a non-zero exponent field
                    mcand_next  = {{M{1'b0}}, |bus.a[W-2 -: EXP_W], bus.a[MAN_W-1:0]};
                    mplier_next = {|bus.b[W-2 -: EXP_W], bus.b[MAN_W-1:0]};
                    acc_next    = '0;
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    state_next  = MULT;
                end
            end
            MULT: begin
                if (mplier_reg[0])
                    acc_next = acc_reg + mcand_reg;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST)
                    state_next = NORM;
            end
            NORM: begin
                result_next = norm_result;
                done_next   = 1'b1;
                busy_next   = 1'b0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            mcand_reg  <= mcand_next;
            acc_reg    <= acc_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign bus.result = result_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = busy_reg;
endmodule

// File: tb/tb_fpu_mult_seq.sv
// Directed vectors for fpu_mult_seq: value table plus handshake and reset sequences.
module tb_fpu_mult_seq;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    fpu_mult_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpu_mult_seq #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expect_r;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e, input string name);
        vec_t v;
        v.a = a; v.b = b; v.expect_r = e; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] ev, input string name);
        int cyc;
        bit seen;
        bit busy_dropped;
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        busy_dropped = 1'b0;
        while (!seen && cyc < 40) begin
            if (!bus.busy) busy_dropped = 1'b1;
            @(posedge clock); #1;
            cyc++;
            seen = bus.done;
        end
        check({name, "_latency"}, 32'(cyc), 32'd25);
        check({name, "_busy_held"}, {31'd0, busy_dropped}, 32'd0);
        check({name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_result"}, bus.result, ev);
        $display("op %s a=%h b=%h result=%h latency=%0d", name, av, bv, bus.result, cyc);
        @(posedge clock); #1;
        check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({name, "_result_hold"}, bus.result, ev);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        reset = 1'b1;

        add_vec(32'h3FC00000, 32'h40000000, 32'h40400000, "mul_1p5_x_2");
        add_vec(32'hC0000000, 32'h40400000, 32'hC0C00000, "mul_m2_x_3");
        add_vec(32'hBFC00000, 32'hBFC00000, 32'h40100000, "mul_m1p5_sq");
        add_vec(32'h3F800001, 32'h3F800001, 32'h3F800002, "trunc_small");
        add_vec(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, "trunc_max");
        add_vec(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero");
        add_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in");
        add_vec(32'h80000000, 32'h40400000, 32'h80000000, "negzero_x_3");
        add_vec(32'hFF800000, 32'h40000000, 32'hFF800000, "neginf_x_2");
        add_vec(32'hFF800000, 32'hFF800000, 32'h7F800000, "neginf_sq");
        add_vec(32'h00000001, 32'h3F800000, 32'h00000000, "denorm_flush");
        add_vec(32'h7F000000, 32'h7F000000, 32'h7F800000, "overflow");
        add_vec(32'h7F000000, 32'h40000000, 32'h7F800000, "overflow_edge");
        add_vec(32'h7F000000, 32'h3F800000, 32'h7F000000, "max_exp_ok");
        add_vec(32'h00800000, 32'h00800000, 32'h00000000, "underflow");
        add_vec(32'h00800000, 32'h3F000000, 32'h00000000, "underflow_edge");
        add_vec(32'h00800000, 32'h3F800000, 32'h00800000, "min_exp_ok");

        repeat (3) @(posedge clock);
        #1;
        check("reset_result", bus.result, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].expect_r, vecs[i].name);

        // start held for 30 cycles, operands changed mid-operation
        bus.a = 32'h3FC00000;
        bus.b = 32'h40000000;
        bus.start = 1'b1;
        @(posedge clock); #1;
        for (int i = 1; i <= 55; i++) begin
            if (i == 5) begin
                bus.a = 32'hC0000000;
                bus.b = 32'h40400000;
            end
            if (i == 30) bus.start = 1'b0;
            @(posedge clock); #1;
            if (i == 25) begin
                check("hold_first_done", {31'd0, bus.done}, 32'd1);
                check("hold_first_result", bus.result, 32'h40400000);
                $display("op hold_first result=%h at cycle %0d", bus.result, i);
            end else if (i == 51) begin
                check("hold_second_done", {31'd0, bus.done}, 32'd1);
                check("hold_second_result", bus.result, 32'hC0C00000);
                $display("op hold_second result=%h at cycle %0d", bus.result, i);
            end else begin
                check($sformatf("hold_no_done_c%0d", i), {31'd0, bus.done}, 32'd0);
                if (i >= 26 && i <= 50) begin
                    check($sformatf("hold_result_stable_c%0d", i), bus.result, 32'h40400000);
                    check($sformatf("hold_second_busy_c%0d", i), {31'd0, bus.busy}, 32'd1);
                end
            end
        end

        // Abort with reset 10 edges into an operation
        begin
            bit seen;
            bus.a = 32'h40000000;
            bus.b = 32'h40400000;
            bus.start = 1'b1;
            @(posedge clock); #1;
            bus.start = 1'b0;
            repeat (10) @(posedge clock);
            #1;
            reset = 1'b1;
            #1;
            check("abort_result", bus.result, 32'd0);
            check("abort_busy", {31'd0, bus.busy}, 32'd0);
            check("abort_done", {31'd0, bus.done}, 32'd0);
            @(posedge clock); #1;
            reset = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(posedge clock); #1;
                if (bus.done || bus.busy) seen = 1'b1;
            end
            check("abort_no_done", {31'd0, seen}, 32'd0);
            $display("op abort_reset result=%h", bus.result);
            run_op(32'h40000000, 32'h40400000, 32'h40C00000, "after_abort");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
